rom_burst_fetch: RTL and testbench

Synchronous fetch sequencer that sits directly upstream of an asynchronous EPROM model (27256-class, 150 ns access). It drives the ROM address, CEn and OEn pins and waits a programmable number of clock cycles per byte to cover access time. It reads BURST_LEN consecutive bytes, packs them into one wide word and presents it to the consuming video/CPU logic with a one-cycle valid pulse. One burst is in flight at a time; requests arriving while busy are not queued.

---
 rtl/rom_burst_fetch.sv | 125 ++++++++++++
 tb/tb_rom_burst_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_fetch.sv
// Burst fetch sequencer for an asynchronous byte-wide EPROM: reads BURST_LEN consecutive bytes,
// waiting WAIT_CYCLES clocks per byte, and presents them packed with a one-cycle valid pulse.
module rom_burst_fetch #(
    parameter int unsigned ADDR_WIDTH  = 15,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned BURST_LEN   = 4
) (
    input  logic                             clk,
    input  logic                             RSTn,
    input  logic                             REQ,
    input  logic [ADDR_WIDTH-1:0]            REQ_ADDR,
    output logic                             BUSY,
    output logic [DATA_WIDTH*BURST_LEN-1:0]  RD_DATA,
    output logic                             RD_VALID,
    output logic [ADDR_WIDTH-1:0]            ROM_ADDR,
    output logic                             ROM_CEn,
    output logic                             ROM_OEn,
    input  logic [DATA_WIDTH-1:0]            ROM_DATA
);

    localparam int unsigned WordW = DATA_WIDTH * BURST_LEN;
    localparam int unsigned WaitW = $clog2(WAIT_CYCLES + 1);
    localparam int unsigned IdxW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [WaitW-1:0] WaitInit = WaitW'(WAIT_CYCLES);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(BURST_LEN - 1);

    typedef enum logic {StIdle, StAccess} state_e;

    state_e                  state_q, state_d;
    logic [WaitW-1:0]        wait_q, wait_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    cen_q, cen_d;
    logic                    oen_q, oen_d;
    logic                    busy_q, busy_d;
    logic                    valid_q, valid_d;
    logic [WordW-1:0]        shadow_q, shadow_d;
    logic [WordW-1:0]        rd_data_q, rd_data_d;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            cen_q     <= 1'b1;
            oen_q     <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            shadow_q  <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            cen_q     <= cen_d;
            oen_q     <= oen_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            shadow_q  <= shadow_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        cen_d     = cen_q;
        oen_d     = oen_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        shadow_d  = shadow_q;
        rd_data_d = rd_data_q;

        unique case (state_q)
            StIdle: begin
                if (REQ) begin
                    addr_d  = REQ_ADDR;
                    cen_d   = 1'b0;
                    oen_d   = 1'b0;
                    busy_d  = 1'b1;
                    wait_d  = WaitInit;
                    idx_d   = '0;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                wait_d = wait_q - 1'b1;
                if (wait_q == WaitW'(1)) begin
                    for (int unsigned k = 0; k < BURST_LEN; k++) begin
                        if (idx_q == IdxW'(k)) begin
                            shadow_d[k*DATA_WIDTH +: DATA_WIDTH] = ROM_DATA;
                        end
                    end
                    if (idx_q != IdxLast) begin
                        // Enables stay asserted across bytes; only the address steps.
                        addr_d = addr_q + 1'b1;
                        idx_d  = idx_q + 1'b1;
                        wait_d = WaitInit;
                    end else begin
                        rd_data_d = shadow_d;
                        valid_d   = 1'b1;
                        busy_d    = 1'b0;
                        cen_d     = 1'b1;
                        oen_d     = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign BUSY     = busy_q;
    assign RD_DATA  = rd_data_q;
    assign RD_VALID = valid_q;
    assign ROM_ADDR = addr_q;
    assign ROM_CEn  = cen_q;
    assign ROM_OEn  = oen_q;

endmodule

// File: tb/tb_rom_burst_fetch.sv
// Bench for rom_burst_fetch: 24 MHz clock, EPROM models with byte[a] = a[7:0] ^ 8'h5A.
`timescale 1ns / 1ps
module tb_rom_burst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_valid = 0;
    int          n_accept = 0;

    // Main DUT: default parameters, 150 ns ROM.
    logic        req = 1'b0;
    logic [14:0] req_addr = '0;
    logic        busy, rd_valid, rom_cen, rom_oen;
    logic [31:0] rd_data;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data;

    // Second DUT: WAIT_CYCLES=2, too fast for the 150 ns ROM.
    logic        req2 = 1'b0;
    logic [14:0] req_addr2 = '0;
    logic        busy2, rd_valid2, rom_cen2, rom_oen2;
    logic [31:0] rd_data2;
    logic [14:0] rom_addr2;
    logic [7:0]  rom_data2;

    // Third DUT: WAIT_CYCLES=1, BURST_LEN=1, zero-delay ROM.
    logic        req3 = 1'b0;
    logic [14:0] req_addr3 = '0;
    logic        busy3, rd_valid3, rom_cen3, rom_oen3;
    logic [7:0]  rd_data3;
    logic [14:0] rom_addr3;
    logic [7:0]  rom_data3;

    always #20.833 clk = ~clk;

    rom_burst_fetch dut (
        .clk(clk), .RSTn(rst_n), .REQ(req), .REQ_ADDR(req_addr), .BUSY(busy),
        .RD_DATA(rd_data), .RD_VALID(rd_valid), .ROM_ADDR(rom_addr), .ROM_CEn(rom_cen),
        .ROM_OEn(rom_oen), .ROM_DATA(rom_data)
    );

    rom_burst_fetch #(.WAIT_CYCLES(2)) dut2 (
        .clk(clk), .RSTn(rst_n), .REQ(req2), .REQ_ADDR(req_addr2), .BUSY(busy2),
        .RD_DATA(rd_data2), .RD_VALID(rd_valid2), .ROM_ADDR(rom_addr2), .ROM_CEn(rom_cen2),
        .ROM_OEn(rom_oen2), .ROM_DATA(rom_data2)
    );

    rom_burst_fetch #(.WAIT_CYCLES(1), .BURST_LEN(1)) dut3 (
        .clk(clk), .RSTn(rst_n), .REQ(req3), .REQ_ADDR(req_addr3), .BUSY(busy3),
        .RD_DATA(rd_data3), .RD_VALID(rd_valid3), .ROM_ADDR(rom_addr3), .ROM_CEn(rom_cen3),
        .ROM_OEn(rom_oen3), .ROM_DATA(rom_data3)
    );

    // Access-time model: data is only valid once address and enables have been stable 150 ns.
    wire [16:0] rom_ctl  = {rom_addr, rom_cen, rom_oen};
    wire [16:0] rom_ctl2 = {rom_addr2, rom_cen2, rom_oen2};
    wire [16:0] rom_settled;
    wire [16:0] rom_settled2;
    assign #150 rom_settled  = rom_ctl;
    assign #150 rom_settled2 = rom_ctl2;
    assign rom_data  = (!rom_cen && !rom_oen && rom_settled == rom_ctl)
                       ? (rom_addr[7:0] ^ 8'h5A) : 'x;
    assign rom_data2 = (!rom_cen2 && !rom_oen2 && rom_settled2 == rom_ctl2)
                       ? (rom_addr2[7:0] ^ 8'h5A) : 'x;
    assign rom_data3 = (!rom_cen3 && !rom_oen3) ? (rom_addr3[7:0] ^ 8'h5A) : 'x;

    always @(negedge clk) if (rd_valid) n_valid++;

    typedef struct {
        logic [14:0] addr;
        logic [31:0] data;
        bit          noise;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp,
                         input bit want_equal = 1'b1);
        n_total++;
        if ((got === exp) == want_equal) n_pass++;
        else $display("FAIL %s: got %h, %s %h", name, got,
                      want_equal ? "expected" : "expected anything but", exp);
    endtask

    task automatic check_reset_state(input string name);
        check(name, 64'({busy, rd_valid, rom_cen, rom_oen, rom_addr, rd_data}),
              64'({1'b0, 1'b0, 1'b1, 1'b1, 15'h0, 32'h0}));
    endtask

    // Full burst with per-cycle checks of BUSY/CEn/OEn/RD_VALID/ROM_ADDR; optional REQ noise.
    task automatic run_burst(input logic [14:0] a, input logic [31:0] exp, input bit noise);
        @(negedge clk);
        req = 1'b1;
        req_addr = a;
        @(negedge clk);
        req = 1'b0;
        n_accept++;
        for (int j = 0; j < 16; j++) begin
            if (j > 0) @(negedge clk);
            check("burst_trace", 64'({busy, rom_cen, rom_oen, rd_valid, rom_addr}),
                  64'({1'b1, 1'b0, 1'b0, 1'b0, 15'(a + 15'(j / 4))}));
            if (noise) begin
                req = (j == 3 || j == 10);
                req_addr = 15'h0500;
            end
        end
        @(negedge clk);
        check("burst_done", 64'({busy, rom_cen, rom_oen, rd_valid, rom_addr}),
              64'({1'b0, 1'b1, 1'b1, 1'b1, 15'(a + 15'd3)}));
        check("burst_data", 64'(rd_data), 64'(exp));
        @(negedge clk);
        check("valid_pulse_end", 64'({rd_valid, busy}), 64'({1'b0, 1'b0}));
        check("data_held", 64'(rd_data), 64'(exp));
    endtask

    initial begin
        vec_t vecs[6];
        int   n_valid_before;

        vecs[0] = '{addr: 15'h0010, data: 32'h4948_4B4A, noise: 1'b0};
        vecs[1] = '{addr: 15'h7FFE, data: 32'h5B5A_A5A4, noise: 1'b0};
        vecs[2] = '{addr: 15'h0000, data: 32'h5958_5B5A, noise: 1'b0};
        vecs[3] = '{addr: 15'h1234, data: 32'h6D6C_6F6E, noise: 1'b1};
        vecs[4] = '{addr: 15'h0020, data: 32'h7978_7B7A, noise: 1'b0};
        vecs[5] = '{addr: 15'h7FFF, data: 32'h5A5B_A5A5 ^ 32'h0000_0000, noise: 1'b0};
        // 0x7FFF wraps: bytes A5 (7FFF), 5A (0000), 5B (0001), 58 (0002).
        vecs[5].data = 32'h585B_5AA5;

        repeat (2) @(negedge clk);
        check_reset_state("reset_state");
        check("reset_state_dut3", 64'({busy3, rd_valid3, rom_cen3, rom_oen3, rd_data3}),
              64'({1'b0, 1'b0, 1'b1, 1'b1, 8'h00}));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_burst(vecs[i].addr, vecs[i].data, vecs[i].noise);

        // REQ held high; address changed mid-burst must only affect the next burst.
        @(negedge clk);
        req = 1'b1;
        req_addr = 15'h0000;
        @(negedge clk);
        n_accept++;
        for (int j = 1; j < 16; j++) begin
            @(negedge clk);
            if (j == 5) req_addr = 15'h0140;
            if (j == 8) check("hold_addr_unaffected", 64'(rom_addr), 64'(15'h0002));
        end
        @(negedge clk);
        check("hold_first_valid", 64'({rd_valid, busy}), 64'({1'b1, 1'b0}));
        check("hold_first_data", 64'(rd_data), 64'(32'h5958_5B5A));
        @(negedge clk);
        check("hold_restart", 64'({busy, rom_cen, rom_oen, rd_valid, rom_addr}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 15'h0140}));
        req = 1'b0;
        n_accept++;
        repeat (16) @(negedge clk);
        check("hold_second_valid", 64'({rd_valid, busy}), 64'({1'b1, 1'b0}));
        check("hold_second_data", 64'(rd_data), 64'(32'h1918_1B1A));

        // Asynchronous reset during byte 2 discards the burst.
        @(negedge clk);
        req = 1'b1;
        req_addr = 15'h0040;
        @(negedge clk);
        req = 1'b0;
        repeat (9) @(negedge clk);
        n_valid_before = n_valid;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset_midburst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_valid_after_abort", 64'(n_valid), 64'(n_valid_before));
        run_burst(15'h0020, 32'h7978_7B7A, 1'b0);

        // WAIT_CYCLES=2 samples the ROM before its access time has elapsed.
        @(negedge clk);
        req2 = 1'b1;
        req_addr2 = 15'h0010;
        @(negedge clk);
        req2 = 1'b0;
        repeat (8) @(negedge clk);
        check("wait2_valid", 64'({rd_valid2, busy2}), 64'({1'b1, 1'b0}));
        check("wait2_data_invalid", 64'(rd_data2), 64'(32'h4948_4B4A), 1'b0);

        // Single-byte, single-cycle fetch: no address increment.
        @(negedge clk);
        req3 = 1'b1;
        req_addr3 = 15'h7FFF;
        @(negedge clk);
        req3 = 1'b0;
        check("len1_accept", 64'({busy3, rom_cen3, rom_oen3, rd_valid3, rom_addr3}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 15'h7FFF}));
        @(negedge clk);
        check("len1_done", 64'({busy3, rom_cen3, rom_oen3, rd_valid3, rom_addr3}),
              64'({1'b0, 1'b1, 1'b1, 1'b1, 15'h7FFF}));
        check("len1_data", 64'(rd_data3), 64'(8'hA5));

        repeat (3) @(negedge clk);
        check("valid_count", 64'(n_valid), 64'(n_accept));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
